// File: rtl/vgachargen_pkg.sv
// Shared types for the VGA character generator: timing widths, timing
// config bundle, 640x480 defaults and the timing controller state encoding.
package vgachargen_pkg;

  localparam int VGA_MAX_H_WIDTH = 11;
  localparam int VGA_MAX_V_WIDTH = 10;

  typedef logic [VGA_MAX_H_WIDTH-1:0] hval_t;
  typedef logic [VGA_MAX_V_WIDTH-1:0] vval_t;

  typedef struct packed {
    hval_t hd;
    hval_t hf;
    hval_t hr;
    hval_t hb;
    vval_t vd;
    vval_t vf;
    vval_t vr;
    vval_t vb;
  } vga_timing_t;

  localparam vga_timing_t DEFAULT_640x480 = '{
    hd: 11'd640, hf: 11'd16, hr: 11'd96, hb: 11'd48,
    vd: 10'd480, vf: 10'd10, vr: 10'd2,  vb: 10'd33
  };

  localparam int DEFAULT_DIV = 4;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_LOAD,
    ST_RUN,
    ST_PEND,
    ST_STOP_WAIT
  } ctrl_state_e;

  function automatic hval_t h_total(vga_timing_t t);
    return t.hd + t.hf + t.hr + t.hb;
  endfunction

  function automatic vval_t v_total(vga_timing_t t);
    return t.vd + t.vf + t.vr + t.vb;
  endfunction

  // Two guard bits: four terms can carry past the first extra bit.
  function automatic logic timing_ok(vga_timing_t t);
    logic [VGA_MAX_H_WIDTH+1:0] hs;
    logic [VGA_MAX_V_WIDTH+1:0] vs;
    hs = {2'b00, t.hd} + {2'b00, t.hf}
       + {2'b00, t.hr} + {2'b00, t.hb};
    vs = {2'b00, t.vd} + {2'b00, t.vf}
       + {2'b00, t.vr} + {2'b00, t.vb};
    return (t.hd > t.hf) && (t.hd > t.hr)
        && (t.hd > t.hb) && (t.vd > t.vf)
        && (t.vd > t.vr) && (t.vd > t.vb)
        && (t.hr != '0) && (t.vr != '0)
        && (hs[VGA_MAX_H_WIDTH+1:VGA_MAX_H_WIDTH] == 2'b00)
        && (vs[VGA_MAX_V_WIDTH+1:VGA_MAX_V_WIDTH] == 2'b00);
  endfunction

endpackage

// File: rtl/vga_pixel_en_div.sv
// Pixel-enable divider: strobe every div_i clocks, synchronously cleared.
// Ports: clk_i, arstn_i, clr_i (hold count at 0), div_i, strobe_o.
module vga_pixel_en_div #(
  parameter int DIV_W = 4
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             strobe_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] last;

  assign last     = div_i - DIV_W'(1);
  assign strobe_o = (cnt_q == last);

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (clr_i || strobe_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// Sequences timing_generator: owns active timings, pixel enable, start/stop.
// Ports: cfg_* handshake + err, start/stop, gen counts in, tg_* to generator.
module vga_timing_ctrl
  import vgachargen_pkg::*;
#(
  parameter int DIV_W = 4
) (
  input  logic                       clk_i,
  input  logic                       arstn_i,
  input  logic                       cfg_valid_i,
  output logic                       cfg_ready_o,
  input  logic [VGA_MAX_H_WIDTH-1:0] cfg_hd_i,
  input  logic [VGA_MAX_H_WIDTH-1:0] cfg_hf_i,
  input  logic [VGA_MAX_H_WIDTH-1:0] cfg_hr_i,
  input  logic [VGA_MAX_H_WIDTH-1:0] cfg_hb_i,
  input  logic [VGA_MAX_V_WIDTH-1:0] cfg_vd_i,
  input  logic [VGA_MAX_V_WIDTH-1:0] cfg_vf_i,
  input  logic [VGA_MAX_V_WIDTH-1:0] cfg_vr_i,
  input  logic [VGA_MAX_V_WIDTH-1:0] cfg_vb_i,
  input  logic [DIV_W-1:0]           cfg_div_i,
  output logic                       cfg_err_o,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic [VGA_MAX_H_WIDTH-1:0] hcount_i,
  input  logic [VGA_MAX_V_WIDTH-1:0] vcount_i,
  output logic [VGA_MAX_H_WIDTH-1:0] tg_hd_o,
  output logic [VGA_MAX_H_WIDTH-1:0] tg_hf_o,
  output logic [VGA_MAX_H_WIDTH-1:0] tg_hr_o,
  output logic [VGA_MAX_H_WIDTH-1:0] tg_hb_o,
  output logic [VGA_MAX_V_WIDTH-1:0] tg_vd_o,
  output logic [VGA_MAX_V_WIDTH-1:0] tg_vf_o,
  output logic [VGA_MAX_V_WIDTH-1:0] tg_vr_o,
  output logic [VGA_MAX_V_WIDTH-1:0] tg_vb_o,
  output logic                       tg_we_o,
  output logic                       tg_en_o,
  output logic                       frame_start_o,
  output logic                       running_o
);

  vga_timing_t      cfg;
  vga_timing_t      act_q;
  vga_timing_t      pend_q;
  logic [DIV_W-1:0] act_div_q;
  logic [DIV_W-1:0] pend_div_q;
  ctrl_state_e      state_q;
  logic             rdy_q;
  logic             we_q;
  logic             err_q;
  logic             fs_q;
  logic             pend_vld_q;
  hval_t            htot_q;
  vval_t            vtot_q;
  logic             take;
  logic             cfg_ok;
  logic             active;
  logic             strobe;
  logic             frame_last;

  assign cfg = '{
    hd: cfg_hd_i, hf: cfg_hf_i, hr: cfg_hr_i, hb: cfg_hb_i,
    vd: cfg_vd_i, vf: cfg_vf_i, vr: cfg_vr_i, vb: cfg_vb_i
  };

  assign take   = cfg_valid_i & rdy_q;
  assign cfg_ok = timing_ok(cfg) & (cfg_div_i != '0);
  assign active = state_q inside {ST_RUN, ST_PEND, ST_STOP_WAIT};

  vga_pixel_en_div #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk_i    (clk_i),
    .arstn_i  (arstn_i),
    .clr_i    (!active),
    .div_i    (act_div_q),
    .strobe_o (strobe)
  );

  assign tg_en_o    = strobe & active;
  assign frame_last = tg_en_o
                    && (hcount_i == htot_q - hval_t'(1))
                    && (vcount_i == vtot_q - vval_t'(1));

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q    <= ST_OFF;
      act_q      <= DEFAULT_640x480;
      pend_q     <= DEFAULT_640x480;
      act_div_q  <= DIV_W'(DEFAULT_DIV);
      pend_div_q <= DIV_W'(DEFAULT_DIV);
      rdy_q      <= 1'b1;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      fs_q       <= 1'b0;
      pend_vld_q <= 1'b0;
      htot_q     <= h_total(DEFAULT_640x480);
      vtot_q     <= v_total(DEFAULT_640x480);
    end else begin
      we_q   <= 1'b0;
      err_q  <= 1'b0;
      fs_q   <= frame_last | (state_q == ST_LOAD);
      htot_q <= h_total(act_q);
      vtot_q <= v_total(act_q);
      unique case (state_q)
        ST_OFF: begin
          if (take) begin
            if (cfg_ok) begin
              act_q     <= cfg;
              act_div_q <= cfg_div_i;
            end else begin
              err_q <= 1'b1;
            end
          end
          if (start_i) begin
            state_q <= ST_LOAD;
            we_q    <= 1'b1;
            rdy_q   <= 1'b0;
          end
        end
        ST_LOAD: begin
          state_q <= ST_RUN;
          rdy_q   <= 1'b1;
        end
        ST_RUN: begin
          // stop outranks a simultaneous offer: nothing is taken
          if (stop_i) begin
            state_q <= ST_STOP_WAIT;
            rdy_q   <= 1'b0;
          end else if (take) begin
            if (cfg_ok) begin
              pend_q     <= cfg;
              pend_div_q <= cfg_div_i;
              pend_vld_q <= 1'b1;
              state_q    <= ST_PEND;
              rdy_q      <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_PEND: begin
          if (frame_last) begin
            act_q      <= pend_q;
            act_div_q  <= pend_div_q;
            pend_vld_q <= 1'b0;
            if (stop_i) begin
              state_q <= ST_OFF;
              rdy_q   <= 1'b1;
            end else begin
              state_q <= ST_LOAD;
              we_q    <= 1'b1;
            end
          end else if (stop_i) begin
            state_q <= ST_STOP_WAIT;
          end
        end
        ST_STOP_WAIT: begin
          if (frame_last) begin
            if (pend_vld_q) begin
              act_q     <= pend_q;
              act_div_q <= pend_div_q;
            end
            pend_vld_q <= 1'b0;
            state_q    <= ST_OFF;
            rdy_q      <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_OFF;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign cfg_ready_o   = rdy_q;
  assign cfg_err_o     = err_q;
  assign tg_we_o       = we_q;
  assign frame_start_o = fs_q;
  assign running_o     = (state_q != ST_OFF);

  assign tg_hd_o = act_q.hd;
  assign tg_hf_o = act_q.hf;
  assign tg_hr_o = act_q.hr;
  assign tg_hb_o = act_q.hb;
  assign tg_vd_o = act_q.vd;
  assign tg_vf_o = act_q.vf;
  assign tg_vr_o = act_q.vr;
  assign tg_vb_o = act_q.vb;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: config vectors, random offers vs a model,
// and start/stop/pending sequences against a simple generator stand-in.
module tb_vga_timing_ctrl;
  import vgachargen_pkg::*;

  localparam int HW = VGA_MAX_H_WIDTH;
  localparam int VW = VGA_MAX_V_WIDTH;

  typedef struct {
    int hd; int hf; int hr; int hb;
    int vd; int vf; int vr; int vb;
    int div; int err;
  } rec_t;

  logic          clk_i = 1'b0;
  logic          arstn_i;
  logic          cfg_valid_i, cfg_ready_o, cfg_err_o;
  logic [HW-1:0] cfg_hd_i, cfg_hf_i, cfg_hr_i, cfg_hb_i;
  logic [VW-1:0] cfg_vd_i, cfg_vf_i, cfg_vr_i, cfg_vb_i;
  logic [3:0]    cfg_div_i;
  logic          start_i, stop_i;
  logic [HW-1:0] hcount_i;
  logic [VW-1:0] vcount_i;
  logic [HW-1:0] tg_hd_o, tg_hf_o, tg_hr_o, tg_hb_o;
  logic [VW-1:0] tg_vd_o, tg_vf_o, tg_vr_o, tg_vb_o;
  logic          tg_we_o, tg_en_o, frame_start_o, running_o;

  always #5 clk_i = ~clk_i;

  vga_timing_ctrl #(.DIV_W(4)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_hd_i(cfg_hd_i), .cfg_hf_i(cfg_hf_i),
    .cfg_hr_i(cfg_hr_i), .cfg_hb_i(cfg_hb_i),
    .cfg_vd_i(cfg_vd_i), .cfg_vf_i(cfg_vf_i),
    .cfg_vr_i(cfg_vr_i), .cfg_vb_i(cfg_vb_i),
    .cfg_div_i(cfg_div_i), .cfg_err_o(cfg_err_o),
    .start_i(start_i), .stop_i(stop_i),
    .hcount_i(hcount_i), .vcount_i(vcount_i),
    .tg_hd_o(tg_hd_o), .tg_hf_o(tg_hf_o),
    .tg_hr_o(tg_hr_o), .tg_hb_o(tg_hb_o),
    .tg_vd_o(tg_vd_o), .tg_vf_o(tg_vf_o),
    .tg_vr_o(tg_vr_o), .tg_vb_o(tg_vb_o),
    .tg_we_o(tg_we_o), .tg_en_o(tg_en_o),
    .frame_start_o(frame_start_o), .running_o(running_o)
  );

  // Generator stand-in: raster counters advanced by en, wrap at totals.
  int   gh, gv, htot, vtot, jh, jv;
  logic jump_req = 1'b0;

  assign htot = int'(tg_hd_o) + int'(tg_hf_o)
              + int'(tg_hr_o) + int'(tg_hb_o);
  assign vtot = int'(tg_vd_o) + int'(tg_vf_o)
              + int'(tg_vr_o) + int'(tg_vb_o);
  assign hcount_i = HW'(gh);
  assign vcount_i = VW'(gv);

  always @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      gh <= 0;
      gv <= 0;
    end else if (jump_req) begin
      gh <= jh;
      gv <= jv;
    end else if (tg_en_o) begin
      if (gh >= htot - 1) begin
        gh <= 0;
        gv <= (gv >= vtot - 1) ? 0 : gv + 1;
      end else begin
        gh <= gh + 1;
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int ref_ok(rec_t c);
    if (c.hd <= c.hf || c.hd <= c.hr || c.hd <= c.hb) return 0;
    if (c.vd <= c.vf || c.vd <= c.vr || c.vd <= c.vb) return 0;
    if (c.hr == 0 || c.vr == 0 || c.div == 0) return 0;
    if (c.hd + c.hf + c.hr + c.hb >= (1 << HW)) return 0;
    if (c.vd + c.vf + c.vr + c.vb >= (1 << VW)) return 0;
    return 1;
  endfunction

  task automatic drive(rec_t c);
    cfg_hd_i = HW'(c.hd); cfg_hf_i = HW'(c.hf);
    cfg_hr_i = HW'(c.hr); cfg_hb_i = HW'(c.hb);
    cfg_vd_i = VW'(c.vd); cfg_vf_i = VW'(c.vf);
    cfg_vr_i = VW'(c.vr); cfg_vb_i = VW'(c.vb);
    cfg_div_i = 4'(c.div);
  endtask

  task automatic offer(rec_t c);
    drive(c);
    cfg_valid_i = 1'b1;
    step();
    cfg_valid_i = 1'b0;
  endtask

  task automatic jump(int h, int v);
    jh = h;
    jv = v;
    jump_req = 1'b1;
    step();
    jump_req = 1'b0;
  endtask

  task automatic chk_tg(string nm, rec_t e);
    chk({nm, "_hd"}, int'(tg_hd_o), e.hd);
    chk({nm, "_hf"}, int'(tg_hf_o), e.hf);
    chk({nm, "_hr"}, int'(tg_hr_o), e.hr);
    chk({nm, "_hb"}, int'(tg_hb_o), e.hb);
    chk({nm, "_vd"}, int'(tg_vd_o), e.vd);
    chk({nm, "_vf"}, int'(tg_vf_o), e.vf);
    chk({nm, "_vr"}, int'(tg_vr_o), e.vr);
    chk({nm, "_vb"}, int'(tg_vb_o), e.vb);
  endtask

  task automatic wait_we(string nm, int budget);
    for (int i = 0; i < budget && !tg_we_o; i++) step();
    chk(nm, int'(tg_we_o), 1);
  endtask

  task automatic wait_off(string nm, int budget,
                          output int en_cnt, output int we_cnt);
    en_cnt = 0;
    we_cnt = 0;
    for (int i = 0; i < budget && running_o; i++) begin
      en_cnt += int'(tg_en_o);
      we_cnt += int'(tg_we_o);
      step();
    end
    chk(nm, int'(running_o), 0);
  endtask

  rec_t tbl[11];
  rec_t dflt, c800, bad1, sum2k, div0, tiny, med, rc, exp_tg;
  int   ok, en_cnt, we_cnt;

  initial begin
    dflt  = '{640, 16, 96, 48, 480, 10, 2, 33, 4, 0};
    c800  = '{800, 40, 128, 88, 600, 1, 4, 23, 2, 0};
    bad1  = '{10, 16, 2, 2, 6, 1, 1, 1, 1, 1};
    sum2k = '{1000, 500, 300, 248, 480, 10, 2, 33, 4, 1};
    div0  = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 1};
    tiny  = '{8, 1, 2, 1, 6, 1, 1, 1, 1, 0};
    med   = '{20, 2, 3, 3, 110, 2, 2, 2, 2, 0};

    tbl[0]  = dflt;
    tbl[1]  = bad1;
    tbl[2]  = sum2k;
    tbl[3]  = '{1000, 500, 300, 247, 480, 10, 2, 33, 4, 0};
    tbl[4]  = '{640, 16, 0, 48, 480, 10, 2, 33, 4, 1};
    tbl[5]  = div0;
    tbl[6]  = '{640, 16, 96, 48, 480, 10, 0, 33, 4, 1};
    tbl[7]  = '{640, 16, 96, 48, 500, 400, 100, 23, 3, 0};
    tbl[8]  = '{640, 16, 96, 48, 500, 400, 100, 24, 3, 1};
    tbl[9]  = '{100, 100, 1, 1, 50, 2, 2, 2, 1, 1};
    tbl[10] = '{800, 40, 128, 88, 600, 1, 4, 23, 15, 0};

    arstn_i = 1'b0;
    cfg_valid_i = 1'b0;
    start_i = 1'b0;
    stop_i = 1'b0;
    drive(dflt);
    step();
    step();
    arstn_i = 1'b1;
    step();

    // reset state
    chk("rst_ready", int'(cfg_ready_o), 1);
    chk("rst_en", int'(tg_en_o), 0);
    chk("rst_we", int'(tg_we_o), 0);
    chk("rst_err", int'(cfg_err_o), 0);
    chk("rst_fs", int'(frame_start_o), 0);
    chk("rst_run", int'(running_o), 0);
    chk_tg("rst_tg", dflt);

    // start at default: one-cycle we, first frame_start, en every 4th
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("load_we", int'(tg_we_o), 1);
    chk("load_en", int'(tg_en_o), 0);
    chk("load_hd", int'(tg_hd_o), 640);
    step();
    chk("run_we", int'(tg_we_o), 0);
    chk("run_fs", int'(frame_start_o), 1);
    chk("run_running", int'(running_o), 1);
    for (int i = 0; i < 12; i++) begin
      chk("en_div4", int'(tg_en_o), int'(i % 4 == 3));
      step();
    end

    // mid-frame 800x600 offer held until old frame wraps
    offer(c800);
    chk("pend_ready", int'(cfg_ready_o), 0);
    chk("pend_hd", int'(tg_hd_o), 640);
    jump(790, 524);
    wait_we("pend_we", 400);
    chk_tg("apply800", c800);
    chk("apply_en", int'(tg_en_o), 0);
    chk("apply_h0", int'(hcount_i), 0);
    chk("apply_v0", int'(vcount_i), 0);
    chk("apply_fs", int'(frame_start_o), 1);
    step();
    chk("apply_we_off", int'(tg_we_o), 0);
    chk("apply_fs2", int'(frame_start_o), 1);
    for (int i = 0; i < 6; i++) begin
      chk("en_div2", int'(tg_en_o), int'(i % 2 == 1));
      step();
    end

    // rejected offers in RUN
    offer(bad1);
    chk("bad1_err", int'(cfg_err_o), 1);
    chk("bad1_ready", int'(cfg_ready_o), 1);
    chk("bad1_run", int'(running_o), 1);
    chk("bad1_hd", int'(tg_hd_o), 800);
    step();
    chk("err_clear", int'(cfg_err_o), 0);
    offer(sum2k);
    chk("sum2k_err", int'(cfg_err_o), 1);
    offer(div0);
    chk("div0_err", int'(cfg_err_o), 1);
    chk("div0_hf", int'(tg_hf_o), 40);

    // div 1: enable every cycle
    offer(tiny);
    chk("tiny_err", int'(cfg_err_o), 0);
    chk("tiny_ready", int'(cfg_ready_o), 0);
    jump(1050, 627);
    wait_we("tiny_we", 200);
    chk("tiny_hd", int'(tg_hd_o), 8);
    step();
    for (int i = 0; i < 10; i++) begin
      chk("en_div1", int'(tg_en_o), 1);
      step();
    end

    // stop at vcount 100 finishes the frame
    offer(med);
    wait_we("med_we", 400);
    chk("med_hd", int'(tg_hd_o), 20);
    for (int i = 0; i < 9000 && int'(vcount_i) != 100; i++) step();
    chk("reach_v100", int'(vcount_i), 100);
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    chk("stop_ready", int'(cfg_ready_o), 0);
    chk("stop_run", int'(running_o), 1);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("stopw_start_ign", int'(tg_we_o), 0);
    wait_off("stop_off", 3000, en_cnt, we_cnt);
    chk("stopw_en_seen", int'(en_cnt > 0), 1);
    chk("stopw_we", we_cnt, 0);
    chk("off_h0", int'(hcount_i), 0);
    chk("off_v0", int'(vcount_i), 0);
    chk("off_en", int'(tg_en_o), 0);
    chk("off_ready", int'(cfg_ready_o), 1);
    en_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      en_cnt += int'(tg_en_o);
    end
    chk("off_en_quiet", en_cnt, 0);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("restart_we", int'(tg_we_o), 1);
    chk("restart_hd", int'(tg_hd_o), 20);
    step();
    chk("restart_fs", int'(frame_start_o), 1);
    chk("restart_run", int'(running_o), 1);

    // stop together with an offer: stop wins
    drive(tiny);
    cfg_valid_i = 1'b1;
    stop_i = 1'b1;
    step();
    cfg_valid_i = 1'b0;
    stop_i = 1'b0;
    chk("stopoff_ready", int'(cfg_ready_o), 0);
    chk("stopoff_err", int'(cfg_err_o), 0);
    chk("stopoff_run", int'(running_o), 1);
    jump(20, 115);
    wait_off("stopoff_off", 300, en_cnt, we_cnt);
    chk("stopoff_hd", int'(tg_hd_o), 20);

    // stop while pending: pending applied on reaching OFF, no we
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    offer(tiny);
    chk("pstop_ready", int'(cfg_ready_o), 0);
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    chk("pstop_run", int'(running_o), 1);
    chk("pstop_hd_old", int'(tg_hd_o), 20);
    jump(20, 115);
    wait_off("pstop_off", 300, en_cnt, we_cnt);
    chk("pstop_we", we_cnt, 0);
    chk_tg("pstop_tg", tiny);
    chk("pstop_ready_off", int'(cfg_ready_o), 1);
    we_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      we_cnt += int'(tg_we_o);
    end
    chk("pstop_we_idle", we_cnt, 0);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("pstop_start_we", int'(tg_we_o), 1);
    step();

    // asynchronous reset mid-run
    #2;
    arstn_i = 1'b0;
    #1;
    chk("arst_run", int'(running_o), 0);
    chk("arst_ready", int'(cfg_ready_o), 1);
    chk("arst_hd", int'(tg_hd_o), 640);
    chk("arst_en", int'(tg_en_o), 0);
    step();
    arstn_i = 1'b1;
    step();

    // vector table in OFF: valid configs write tg_* directly
    exp_tg = dflt;
    for (int i = 0; i < 11; i++) begin
      offer(tbl[i]);
      chk($sformatf("vec%0d_err", i), int'(cfg_err_o), tbl[i].err);
      if (tbl[i].err == 0) exp_tg = tbl[i];
      chk($sformatf("vec%0d_hd", i), int'(tg_hd_o), exp_tg.hd);
      chk($sformatf("vec%0d_vb", i), int'(tg_vb_o), exp_tg.vb);
      chk($sformatf("vec%0d_run", i), int'(running_o), 0);
    end

    // random offers against the rule model
    for (int i = 0; i < 150; i++) begin
      rc.hd = int'($urandom_range(1, 1200));
      rc.hf = int'($urandom_range(0, rc.hd));
      rc.hr = int'($urandom_range(0, rc.hd));
      rc.hb = int'($urandom_range(0, rc.hd));
      rc.vd = int'($urandom_range(1, 700));
      rc.vf = int'($urandom_range(0, rc.vd));
      rc.vr = int'($urandom_range(0, rc.vd));
      rc.vb = int'($urandom_range(0, rc.vd));
      rc.div = int'($urandom_range(0, 15));
      rc.err = 0;
      ok = ref_ok(rc);
      offer(rc);
      chk($sformatf("rnd%0d_err", i), int'(cfg_err_o), 1 - ok);
      if (ok != 0) exp_tg = rc;
      chk_tg($sformatf("rnd%0d", i), exp_tg);
    end

    // start with an accepted offer: LOAD uses the new config
    step();
    drive(med);
    cfg_valid_i = 1'b1;
    start_i = 1'b1;
    step();
    cfg_valid_i = 1'b0;
    start_i = 1'b0;
    chk("sa_we", int'(tg_we_o), 1);
    chk_tg("sa_tg", med);
    step();
    chk("sa_fs", int'(frame_start_o), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
